// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one single-port memory.
// Grants are combinational in IDLE; each transaction ends with a one-cycle rvalid pulse from RESP.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wait_q, wait_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win_s;
  logic          gnt0_s;
  logic          gnt1_s;
  logic          done_s;
  logic [DW-1:0] capture_s;

  // Round-robin pick: on a tie the port not served last wins (1 = port 1).
  always_comb begin
    win_s = 1'b0;
    if (m0_req && m1_req) begin
      win_s = ~last_q;
    end else if (m1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state, capture and grant logic for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wait_d    = wait_q;
    err_d     = err_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    done_s    = 1'b0;
    capture_s = {DW{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ACCESS;
          owner_d = win_s;
          gnt0_s  = ~win_s;
          gnt1_s  = win_s;
          wait_d  = 8'd0;
          err_d   = 1'b0;
          if (win_s) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        // A ready in the last allowed cycle still counts as a normal completion.
        if (mem_ready) begin
          state_d   = S_RESP;
          err_d     = 1'b0;
          done_s    = 1'b1;
          capture_s = we_q ? {DW{1'b0}} : mem_rdata;
        end else if ((wait_q + 8'd1) == TIMEOUT_C) begin
          state_d   = S_RESP;
          err_d     = 1'b1;
          done_s    = 1'b1;
          capture_s = {DW{1'b0}};
        end else begin
          wait_d = wait_q + 8'd1;
        end
        if (done_s && owner_q) begin
          rdata1_d = capture_s;
        end else if (done_s) begin
          rdata0_d = capture_s;
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves port 1 as last served so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
      wait_q   <= 8'd0;
      err_q    <= 1'b0;
      rdata0_q <= {DW{1'b0}};
      rdata1_q <= {DW{1'b0}};
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Grants are gated by reset so a held request cannot leak a grant while reset is low.
  assign m0_gnt    = gnt0_s & rst;
  assign m1_gnt    = gnt1_s & rst;
  assign m0_rvalid = (state_q == S_RESP) & ~owner_q;
  assign m1_rvalid = (state_q == S_RESP) & owner_q;
  assign err       = (state_q == S_RESP) & err_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = (state_q == S_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model with its own copy of memory contents.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 4;
  localparam int PH_FREE = 0;
  localparam int PH_MEM = 1;
  localparam int PH_REPLY = 2;

  logic          clk, rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          err, mem_en, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_pass = 0;

  // memory model (what the DUT talks to) and reference contents (what the model predicts)
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] ref_arr [logic [AW-1:0]];
  int ws_cfg, cur_ws, acc_cnt, last_acc_len;

  // transaction-level reference model
  int            phase, m_mcyc;
  bit            m_last, m_owner, m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_res;
  logic [DW-1:0] m_hold [2];

  // values sampled at the last check point
  logic          s_g0, s_g1, s_rv0, s_rv1, s_err;
  logic [DW-1:0] s_rd0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return DW'(a) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
  endfunction

  // Memory responder: ready after cur_ws wait states, random ready outside accesses.
  task automatic mem_drive();
    if (mem_en === 1'b1) begin
      if (acc_cnt == 0) cur_ws = (ws_cfg < 0) ? int'($urandom_range(0, 5)) : ws_cfg;
      if (acc_cnt == cur_ws) begin
        mem_ready = 1'b1;
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        mem_rdata = mem_we ? DW'($urandom) : mem_read(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = DW'($urandom);
      end
      acc_cnt++;
    end else begin
      if (acc_cnt != 0) last_acc_len = acc_cnt;
      acc_cnt = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
    end
  endtask

  task automatic check_cycle();
    logic e_g0, e_g1, e_en, e_rv0, e_rv1;
    bit win;
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
    s_err = err; s_rd0 = m0_rdata;
    if (rst !== 1'b1) begin
      chk("rst_m0_gnt", m0_gnt, 0);     chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0); chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_err", err, 0);           chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_m0_rdata", m0_rdata, 0); chk("rst_m1_rdata", m1_rdata, 0);
      phase = PH_FREE; m_last = 1'b1; m_hold[0] = '0; m_hold[1] = '0;
      return;
    end
    e_g0 = 1'b0; e_g1 = 1'b0; e_en = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    win = (m0_req && m1_req) ? !m_last : m1_req;
    if (phase == PH_FREE && (m0_req || m1_req)) begin
      if (win) e_g1 = 1'b1; else e_g0 = 1'b1;
    end
    if (phase == PH_MEM) e_en = 1'b1;
    if (phase == PH_REPLY) begin
      if (m_owner) e_rv1 = 1'b1; else e_rv0 = 1'b1;
    end
    chk("m0_gnt", m0_gnt, e_g0);       chk("m1_gnt", m1_gnt, e_g1);
    chk("mem_en", mem_en, e_en);
    chk("m0_rvalid", m0_rvalid, e_rv0); chk("m1_rvalid", m1_rvalid, e_rv1);
    chk("m0_rdata", m0_rdata, m_hold[0]); chk("m1_rdata", m1_rdata, m_hold[1]);
    if (phase == PH_MEM) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (phase == PH_REPLY) chk("err", err, m_err);
    case (phase)
      PH_FREE: if (m0_req || m1_req) begin
        m_owner = win;
        m_we    = win ? m1_we : m0_we;
        m_addr  = win ? m1_addr : m0_addr;
        m_wdata = win ? m1_wdata : m0_wdata;
        m_mcyc  = 0;
        phase   = PH_MEM;
      end
      PH_MEM: begin
        m_mcyc++;
        if (mem_ready) begin
          m_res = m_we ? '0 : ref_read(m_addr);
          if (m_we) ref_arr[m_addr] = m_wdata;
          m_err = 1'b0;
          m_hold[m_owner] = m_res;
          phase = PH_REPLY;
        end else if (m_mcyc == TMO) begin
          m_err = 1'b1;
          m_hold[m_owner] = '0;
          phase = PH_REPLY;
        end
      end
      default: begin
        m_last = m_owner;
        phase = PH_FREE;
      end
    endcase
  endtask

  // One clock: check at the falling edge, then update memory response after the rising edge.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  int t_g0, t_rv0, t_g1, t_rv1, n_g;
  int gseq [6];
  bit got, rv1_seen;
  logic [DW-1:0] rd;
  logic e;

  initial begin
    rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44; m1_wdata = '0;
    ws_cfg = 0; cur_ws = 0; acc_cnt = 0; last_acc_len = 0;
    phase = PH_FREE; m_last = 1'b1; m_hold[0] = '0; m_hold[1] = '0;
    repeat (3) tick();

    // tie at reset exit with zero wait states
    rst = 1'b1;
    t_g0 = -1; t_rv0 = -1; t_g1 = -1; t_rv1 = -1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_g0 && t_g0 < 0) t_g0 = c;
      if (s_rv0 && t_rv0 < 0) t_rv0 = c;
      if (s_g1 && t_g1 < 0) t_g1 = c;
      if (s_rv1 && t_rv1 < 0) t_rv1 = c;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("tie_m0_gnt_cycle", t_g0, 0);   chk("tie_m0_rvalid_cycle", t_rv0, 2);
    chk("tie_m1_gnt_cycle", t_g1, 3);   chk("tie_m1_rvalid_cycle", t_rv1, 5);
    repeat (4) tick();

    // both requests held: grants alternate
    ws_cfg = 1; m1_we = 1'b1; m1_wdata = 32'h1234_5678;
    m0_req = 1'b1; m1_req = 1'b1; n_g = 0;
    for (int i = 0; i < 6; i++) gseq[i] = 9;
    for (int c = 0; c < 60 && n_g < 6; c++) begin
      tick();
      if (s_g0) begin gseq[n_g] = 0; n_g++; end
      else if (s_g1) begin gseq[n_g] = 1; n_g++; end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    chk("alt_grant_count", n_g, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("alt_grant_%0d", i), gseq[i], i % 2);
    repeat (8) tick();

    // write then read back with two wait states
    ws_cfg = 2;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF;
    tick();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h77; m0_wdata = 32'h0;
    repeat (7) tick();
    chk("wr_mem_en_len", last_acc_len, 3);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    tick();
    m0_req = 1'b0; got = 1'b0; rd = '0; e = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (s_rv0 && !got) begin got = 1'b1; rd = s_rd0; e = s_err; end
    end
    chk("rd_rvalid_seen", got, 1); chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_err", e, 0);           chk("rd_mem_en_len", last_acc_len, 3);

    // memory never ready: timeout after TMO access cycles
    ws_cfg = 1000;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    tick();
    m0_req = 1'b0; got = 1'b0; rd = 32'hFFFF_FFFF; e = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_rv0) begin got = 1'b1; rd = s_rd0; e = s_err; break; end
    end
    chk("tmo_rvalid_seen", got, 1); chk("tmo_err", e, 1);
    chk("tmo_rdata", rd, 0);        chk("tmo_mem_en_len", last_acc_len, TMO);
    ws_cfg = 0; m0_req = 1'b1;
    tick();
    chk("tmo_back_to_idle_gnt", s_g0, 1);
    m0_req = 1'b0;
    repeat (6) tick();

    // reset in the memory cycle of a port 1 read
    ws_cfg = 3;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    tick();
    m1_req = 1'b0;
    chk("abort_in_access", mem_en, 1);
    rst = 1'b0;
    #1;
    chk("abort_m0_gnt", m0_gnt, 0);     chk("abort_m1_gnt", m1_gnt, 0);
    chk("abort_m1_rvalid", m1_rvalid, 0); chk("abort_err", err, 0);
    chk("abort_mem_en", mem_en, 0);     chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0); chk("abort_m0_rdata", m0_rdata, 0);
    m0_req = 1'b1; m1_req = 1'b1; rv1_seen = 1'b0;
    repeat (2) begin tick(); rv1_seen = rv1_seen | s_rv1; end
    rst = 1'b1;
    tick();
    chk("post_reset_tie_m0", s_g0, 1); chk("post_reset_tie_not_m1", s_g1, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (8) begin tick(); rv1_seen = rv1_seen | s_rv1; end
    chk("no_m1_rvalid_after_abort", rv1_seen, 0);

    // randomized traffic, inputs changing every cycle
    ws_cfg = -1;
    for (int c = 0; c < 400; c++) begin
      m0_req = ($urandom_range(0, 2) != 0); m0_we = 1'($urandom_range(0, 1));
      m0_addr = AW'($urandom_range(0, 7) * 4); m0_wdata = DW'($urandom);
      m1_req = ($urandom_range(0, 2) != 0); m1_we = 1'($urandom_range(0, 1));
      m1_addr = AW'($urandom_range(0, 7) * 4); m1_wdata = DW'($urandom);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 32, address width; DW, default 32, data width; TIMEOUT, default 255, maximum wait cycles for mem_ready (1..255).
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  port 0 (core) access request
- m0_we  in  1  port 0 write enable (1=write, 0=read)
- m0_addr  in  AW  port 0 address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 request accepted (1-cycle pulse)
- m0_rvalid  out  1  port 0 transaction complete (1-cycle pulse)
- m0_rdata  out  DW  port 0 read data, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1 (debug/loader)
- err  out  1  timeout flag, valid with either rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory access complete

Function
REQ-003 SHALL share one single-port memory between two requesters, one transaction at a time.
REQ-004 SHALL implement states IDLE, ACCESS, RESP.
REQ-005 In IDLE with at least one req high: SHALL select a winner, pulse that port's gnt combinationally in the same cycle, latch its we/addr/wdata at the clock edge, and go to ACCESS.
REQ-006 Arbitration SHALL be round-robin: with both req high, the port not served last wins; with one req high, that port wins regardless of history.
REQ-007 IDLE with no req SHALL stay in IDLE with all gnt low.
REQ-008 ACCESS SHALL drive mem_en=1 and mem_we/mem_addr/mem_wdata from the latched values, held stable until exit.
REQ-009 ACCESS SHALL go to RESP at the edge where mem_ready=1, capturing mem_rdata for reads and DW'0 for writes.
REQ-010 ACCESS SHALL count wait cycles (8-bit), cleared on entry; if the count reaches TIMEOUT with mem_ready low, it SHALL go to RESP with err=1 and rdata=0.
REQ-011 RESP SHALL pulse the owner's rvalid for exactly 1 cycle with rdata and err, update the last-served pointer to the owner, and return to IDLE.
REQ-012 Non-owner rvalid/gnt SHALL stay 0; rdata outputs SHALL hold the last captured value.
REQ-013 Minimum transaction latency: gnt in cycle N, mem_en in cycle N+1, rvalid in cycle N+2 when mem_ready=1 in cycle N+1; back-to-back period of 3 cycles.
REQ-014 Changes to req/addr/we/wdata after gnt SHALL not affect the transaction in flight; a requester holding req high after its rvalid is considered again in the next IDLE.
REQ-015 mem_ready SHALL be ignored outside ACCESS; mem_en SHALL be 0 outside ACCESS.

Reset
REQ-016 rst low SHALL immediately force: state IDLE; all gnt, rvalid, err, mem_en, mem_we 0; mem_addr, mem_wdata, rdata, and wait counter 0; last-served pointer = port 1 (port 0 wins the first tie).
REQ-017 Reset during ACCESS or RESP SHALL abort the transaction with no rvalid issued.

Verification
REQ-018 Both req high in reset-exit cycle, mem_ready tied 1 -> m0_gnt cycle 0, m0_rvalid cycle 2, m1_gnt cycle 3, m1_rvalid cycle 5.
REQ-019 m0 write addr 0x10, data 0xDEADBEEF, then m0 read addr 0x10, memory model with 2 wait states -> mem_en high for 3 cycles per access; m0_rdata=0xDEADBEEF with m0_rvalid; err=0.
REQ-020 Both req held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-021 mem_ready held 0, TIMEOUT=4 -> 4 ACCESS cycles, then the owner's rvalid with err=1 and rdata=0, and state back to IDLE.
REQ-022 rst asserted in the mem_en cycle of an m1 read -> all outputs 0 in the same cycle; no m1_rvalid after release; next tie goes to m0.
